elevator_request_scheduler: RTL and testbench

- Request-side counterpart of the elevator controller/datapath pair. It collects floor-call button presses into a pending set and drives the target floor (Req_floor) into the datapath.
- It watches the controller's arrival and door status to retire served calls.
- Scheduling policy is LOOK: keep travelling in the current direction while calls remain that way, then reverse.

---
 rtl/elevator_pkg.sv | 14 +
 rtl/elevator_request_scheduler_if.sv | 25 ++
 rtl/elevator_floor_select.sv | 40 ++++
 rtl/elevator_request_scheduler.sv | 127 ++++++++++++
 tb/tb_elevator_request_scheduler.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler: FSM state encoding
// and default floor-count parameters.
package elevator_pkg;
  localparam int NUM_FLOORS_DEF = 4;
  localparam int FLOOR_W_DEF    = 2;
  localparam int STATE_W        = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2,
    DWELL      = 2'd3
  } state_t;
endpackage

// File: rtl/elevator_request_scheduler_if.sv
// Call/status/target bundle between the request scheduler and the car side
// (buttons, controller status, datapath target).
interface elevator_request_scheduler_if #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS_DEF,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W_DEF
) ();
  logic [NUM_FLOORS-1:0] call_btn;
  logic [FLOOR_W-1:0]    current_floor;
  logic                  door_open;
  logic                  wait_complete;
  logic [FLOOR_W-1:0]    req_floor;
  logic                  req_valid;
  logic                  direction_up;
  logic [NUM_FLOORS-1:0] pending;

  modport master (
    input  call_btn, current_floor, door_open, wait_complete,
    output req_floor, req_valid, direction_up, pending
  );

  modport slave (
    output call_btn, current_floor, door_open, wait_complete,
    input  req_floor, req_valid, direction_up, pending
  );
endinterface

// File: rtl/elevator_floor_select.sv
// Combinational LOOK search over the pending set relative to the car:
// nearest call at/above, nearest at/below, and any call strictly beyond.
module elevator_floor_select #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS_DEF,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W_DEF
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    above,
  output logic                  above_found,
  output logic [FLOOR_W-1:0]    below,
  output logic                  below_found,
  output logic                  beyond_up,
  output logic                  beyond_down
);
  always_comb begin
    above       = '0;
    above_found = 1'b0;
    below       = '0;
    below_found = 1'b0;
    beyond_up   = 1'b0;
    beyond_down = 1'b0;
    // Descending scan: the last hit is the lowest qualifying floor.
    for (int i = NUM_FLOORS-1; i >= 0; i--) begin
      if (pending[i] && (FLOOR_W'(i) >= current_floor)) begin
        above       = FLOOR_W'(i);
        above_found = 1'b1;
      end
    end
    // Ascending scan: the last hit is the highest qualifying floor.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) <= current_floor)) begin
        below       = FLOOR_W'(i);
        below_found = 1'b1;
      end
      if (pending[i] && (FLOOR_W'(i) > current_floor)) beyond_up   = 1'b1;
      if (pending[i] && (FLOOR_W'(i) < current_floor)) beyond_down = 1'b1;
    end
  end
endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK request scheduler: queues floor calls, drives a registered target floor,
// and retires calls on door-open arrival at the target.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = NUM_FLOORS_DEF,
  parameter int FLOOR_W    = FLOOR_W_DEF
) (
  input logic                         clk,
  input logic                         rst,
  elevator_request_scheduler_if.master bus
);
  state_t                state, state_n;
  logic [NUM_FLOORS-1:0] pending, pending_n, clr_mask;
  logic [FLOOR_W-1:0]    req_floor, req_floor_n;
  logic                  req_valid, req_valid_n;
  logic                  dir_up, dir_up_n;
  logic [FLOOR_W-1:0]    above, below;
  logic                  above_found, below_found, beyond_up, beyond_down;
  logic                  service;

  elevator_floor_select #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_sel (
    .pending      (pending),
    .current_floor(bus.current_floor),
    .above        (above),
    .above_found  (above_found),
    .below        (below),
    .below_found  (below_found),
    .beyond_up    (beyond_up),
    .beyond_down  (beyond_down)
  );

  assign service = ((state == SERVE_UP) || (state == SERVE_DOWN)) &&
                   bus.door_open && (bus.current_floor == req_floor);

  // Clearing at the car's floor beats a same-cycle press there, so a press at
  // an open door is absorbed rather than re-queued.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++)
      clr_mask[i] = (service || (state == DWELL)) && (bus.current_floor == FLOOR_W'(i));
  end

  assign pending_n = (pending | bus.call_btn) & ~clr_mask;

  always_comb begin
    state_n     = state;
    req_floor_n = req_floor;
    req_valid_n = req_valid;
    dir_up_n    = dir_up;
    case (state)
      IDLE: begin
        req_valid_n = 1'b0;
        req_floor_n = bus.current_floor;
        if (|pending) begin
          req_valid_n = 1'b1;
          if (above_found) begin
            state_n = SERVE_UP;   dir_up_n = 1'b1; req_floor_n = above;
          end else begin
            state_n = SERVE_DOWN; dir_up_n = 1'b0; req_floor_n = below;
          end
        end
      end
      SERVE_UP: begin
        if (service) begin
          state_n = DWELL; req_floor_n = bus.current_floor; req_valid_n = 1'b1;
        end else if (above_found) begin
          req_floor_n = above;
        end else if (below_found) begin
          state_n = SERVE_DOWN; dir_up_n = 1'b0; req_floor_n = below;
        end else begin
          state_n = IDLE; req_valid_n = 1'b0; req_floor_n = bus.current_floor;
        end
      end
      SERVE_DOWN: begin
        if (service) begin
          state_n = DWELL; req_floor_n = bus.current_floor; req_valid_n = 1'b1;
        end else if (below_found) begin
          req_floor_n = below;
        end else if (above_found) begin
          state_n = SERVE_UP; dir_up_n = 1'b1; req_floor_n = above;
        end else begin
          state_n = IDLE; req_valid_n = 1'b0; req_floor_n = bus.current_floor;
        end
      end
      DWELL: begin
        // No timeout: the car holds here until the datapath reports dwell done.
        if (bus.wait_complete) begin
          if ((dir_up && beyond_up) || (!dir_up && beyond_down)) begin
            state_n     = dir_up ? SERVE_UP : SERVE_DOWN;
            req_floor_n = dir_up ? above : below;
          end else if ((dir_up && beyond_down) || (!dir_up && beyond_up)) begin
            state_n     = dir_up ? SERVE_DOWN : SERVE_UP;
            req_floor_n = dir_up ? below : above;
            dir_up_n    = !dir_up;
          end else begin
            state_n     = IDLE;
            req_valid_n = 1'b0;
            req_floor_n = bus.current_floor;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pending   <= '0;
      req_floor <= '0;
      req_valid <= 1'b0;
      dir_up    <= 1'b1;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      req_floor <= req_floor_n;
      req_valid <= req_valid_n;
      dir_up    <= dir_up_n;
    end
  end

  assign bus.pending      = pending;
  assign bus.req_floor    = req_floor;
  assign bus.req_valid    = req_valid;
  assign bus.direction_up = dir_up;
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed vector bench for the LOOK request scheduler: table of hand-computed
// post-edge outputs, plus dwell-hold and asynchronous-reset sequences.
module tb_elevator_request_scheduler;
  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  elevator_request_scheduler_if #(.NUM_FLOORS(4), .FLOOR_W(2)) bus ();

  elevator_request_scheduler #(.NUM_FLOORS(4), .FLOOR_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [1:0] cf;
    logic       door;
    logic       wc;
    logic [3:0] pend;
    logic [1:0] rf;
    logic       rv;
    logic       dir;
  } vec_t;

  localparam int NV = 28;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic r, input logic [3:0] btn, input logic [1:0] cf,
                              input logic door, input logic wc, input logic [3:0] pend,
                              input logic [1:0] rf, input logic rv, input logic dir);
    vec_t v;
    v.rst = r; v.btn = btn; v.cf = cf; v.door = door; v.wc = wc;
    v.pend = pend; v.rf = rf; v.rv = rv; v.dir = dir;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %b expected %b", nm, idx, act, exp);
    end
  endtask

  task automatic cmp(input vec_t v, input int idx);
    chk("pending",      idx, bus.pending,                  v.pend);
    chk("req_floor",    idx, {2'b00, bus.req_floor},       {2'b00, v.rf});
    chk("req_valid",    idx, {3'b000, bus.req_valid},      {3'b000, v.rv});
    chk("direction_up", idx, {3'b000, bus.direction_up},   {3'b000, v.dir});
  endtask

  task automatic drive(input vec_t v);
    rst               = v.rst;
    bus.call_btn      = v.btn;
    bus.current_floor = v.cf;
    bus.door_open     = v.door;
    bus.wait_complete = v.wc;
  endtask

  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    cmp(v, idx);
  endtask

  initial begin
    rst = 1'b0;
    bus.call_btn = 4'b1111;
    bus.current_floor = 2'd0;
    bus.door_open = 1'b0;
    bus.wait_complete = 1'b0;

    //               rst btn      cf door wc  pend     rf rv dir
    // reset hold, then release
    vecs[0]  = mk(0, 4'b1111, 0, 0, 0, 4'b0000, 0, 0, 1);
    vecs[1]  = mk(1, 4'b1111, 0, 0, 0, 4'b1111, 0, 0, 1);
    vecs[2]  = mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1);
    // single call to floor 3
    vecs[3]  = mk(1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 1);
    vecs[4]  = mk(1, 4'b0000, 0, 0, 0, 4'b1000, 3, 1, 1);
    vecs[5]  = mk(1, 4'b0000, 1, 0, 0, 4'b1000, 3, 1, 1);
    vecs[6]  = mk(1, 4'b0000, 3, 1, 0, 4'b0000, 3, 1, 1);
    vecs[7]  = mk(1, 4'b0000, 3, 1, 0, 4'b0000, 3, 1, 1);
    vecs[8]  = mk(1, 4'b0000, 3, 0, 1, 4'b0000, 3, 0, 1);
    vecs[9]  = mk(1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1);
    // preemption: heading to 3, call at 1 takes over
    vecs[10] = mk(1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0, 1);
    vecs[11] = mk(1, 4'b0000, 0, 0, 0, 4'b1000, 3, 1, 1);
    vecs[12] = mk(1, 4'b0010, 0, 0, 0, 4'b1010, 3, 1, 1);
    vecs[13] = mk(1, 4'b0000, 0, 0, 0, 4'b1010, 1, 1, 1);
    vecs[14] = mk(1, 4'b0000, 1, 1, 0, 4'b1000, 1, 1, 1);
    vecs[15] = mk(1, 4'b0000, 1, 1, 0, 4'b1000, 1, 1, 1);
    vecs[16] = mk(1, 4'b0000, 1, 0, 1, 4'b1000, 3, 1, 1);
    // reversal: at 2 going up, call at 0 deferred until 3 served
    vecs[17] = mk(1, 4'b0001, 2, 0, 0, 4'b1001, 3, 1, 1);
    vecs[18] = mk(1, 4'b0000, 2, 0, 0, 4'b1001, 3, 1, 1);
    vecs[19] = mk(1, 4'b0000, 3, 1, 0, 4'b0001, 3, 1, 1);
    vecs[20] = mk(1, 4'b0000, 3, 0, 1, 4'b0001, 0, 1, 0);
    // clear-wins: call at 2 during down sweep, then presses during dwell at 2
    vecs[21] = mk(1, 4'b0100, 2, 0, 0, 4'b0101, 0, 1, 0);
    vecs[22] = mk(1, 4'b0000, 2, 0, 0, 4'b0101, 2, 1, 0);
    vecs[23] = mk(1, 4'b0000, 2, 1, 0, 4'b0001, 2, 1, 0);
    vecs[24] = mk(1, 4'b0110, 2, 1, 0, 4'b0011, 2, 1, 0);
    vecs[25] = mk(1, 4'b0100, 2, 1, 0, 4'b0011, 2, 1, 0);
    vecs[26] = mk(1, 4'b0000, 2, 0, 1, 4'b0011, 1, 1, 0);
    vecs[27] = mk(1, 4'b0000, 1, 1, 0, 4'b0001, 1, 1, 0);

    for (int i = 0; i < NV; i++) step(vecs[i], i);

    // dwell with no wait_complete holds indefinitely
    for (int i = 0; i < 12; i++)
      step(mk(1, 4'b0000, 1, 0, 0, 4'b0001, 1, 1, 0), 100 + i);
    step(mk(1, 4'b0000, 1, 0, 1, 4'b0001, 0, 1, 0), 120);

    // async reset mid-sweep with pending=0110
    step(mk(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 1), 200);
    step(mk(1, 4'b0110, 0, 0, 0, 4'b0110, 0, 0, 1), 201);
    step(mk(1, 4'b0000, 0, 0, 0, 4'b0110, 1, 1, 1), 202);
    @(negedge clk);
    bus.current_floor = 2'd1;
    #2;
    rst = 1'b0;
    #1;
    cmp(mk(0, 4'b0000, 1, 0, 0, 4'b0000, 0, 0, 1), 203);
    step(mk(0, 4'b1111, 1, 0, 0, 4'b0000, 0, 0, 1), 204);
    step(mk(1, 4'b0000, 1, 0, 0, 4'b0000, 1, 0, 1), 205);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
